regbank_wb_arbiter: RTL and testbench
=====================================

Name: regbank_wb_arbiter

Overview:
- Write-back arbiter and strobe sequencer for the 16 x 32-bit register bank's single write port (des1, w1, load).
- Shares that port between NREQ write-back requesters (ALU, memory, multiplier) using round-robin arbitration.
- Captures the winner's address and data, then generates a clean single-cycle load pulse with data held stable before, during and after it.
- Discards writes to r0 and acknowledges each requester once its write has completed.

Parameters:
NREQ, 3, number of write-back requesters (2..8)
DW, 32, register data width
AW, 4, register address width (16 registers)

Ports:
clock  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req  input  NREQ  per-requester write request; held high until matching ack
req_addr  input  NREQ*AW  packed destination register per requester (requester i at bits [i*AW +: AW])
req_data  input  NREQ*DW  packed write data per requester (requester i at bits [i*DW +: DW])
ack  output  NREQ  one-cycle write-complete pulse per requester
load  output  1  write strobe to register bank (bank latches on rising edge of load)
des1  output  AW  destination address to register bank
w1  output  DW  write data to register bank
busy  output  1  high in any state other than IDLE
grant_id  output  3  index of the current/last granted requester

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; load=0, ack=0, des1=0, w1=0, busy=0, grant_id=0; round-robin pointer=0 (requester 0 highest priority).
- Outputs are registered. No combinational path from req to any output.
- FSM states: IDLE, SETUP, STROBE, RELEASE.
- IDLE:
  - If any req is high, select a winner round-robin, starting from the index after the last granted requester (from 0 after reset).
  - Capture the winner's req_addr into des1 and req_data into w1, set grant_id, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (1 cycle): des1/w1 stable, load=0.
  - If des1==0, go to RELEASE (r0 write dropped, no strobe).
  - Else go to STROBE.
- STROBE (1 cycle): load=1, des1/w1 unchanged.
- RELEASE (1 cycle): load=0, des1/w1 still held; ack[grant_id]=1 for exactly this cycle; round-robin pointer advances to grant_id+1 (mod NREQ).
  - If any req other than grant_id is high, arbitrate among those requesters, capture the new winner and go directly to SETUP.
  - Otherwise go to IDLE.
- Latency: req rising while idle at cycle T -> SETUP at T+1, load=1 at T+2, ack at T+3. Sustained throughput is one write per 3 cycles.
- Capture rule: address and data are sampled only at grant. Changes on req_addr/req_data after grant do not affect the write in flight.
- Requester obligation: deassert req the cycle after ack. The arbiter ignores the just-acked requester's req in the RELEASE decision.
- des1/w1 hold their last values while in IDLE. load is never high for more than one consecutive cycle.
- Simultaneous requests: lowest index at or after the pointer wins. There is no starvation; each waiting requester is served within NREQ grants.
- Reset mid-operation: the next edge forces IDLE and load=0 with no ack. An in-flight write whose strobe already fired stays written. The requester re-requests after reset.
- grant_id is zero-extended when NREQ < 8.

Optional Feature:
- Macro: REGBANK_WB_STATS_EN.
- Defined:
  - Adds output wr_count (16 bits), incremented in every STROBE cycle, wrapping 0xFFFF->0.
  - Adds output drop_count (16 bits), incremented on every RELEASE that follows a des1==0 grant.
  - Both counters reset to 0 on rst.
- Not defined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- Reset then req[0]=1, addr=5, data=0xDEADBEEF at T -> des1=5, w1=0xDEADBEEF at T+1; load=1 only at T+2; ack[0]=1 only at T+3; busy=0 at T+4.
- req[0], req[1], req[2] all high at T with addrs 1/2/3 -> grant order 0,1,2; load pulses at T+2, T+5, T+8; acks at T+3, T+6, T+9.
- req[1]=1 with addr=0 -> no load pulse; ack[1] two cycles after grant; with REGBANK_WB_STATS_EN, drop_count=1 and wr_count=0.
- Grant req[2] (addr=7, data=0x11), then change req_data to 0x22 during SETUP -> w1 remains 0x11 through RELEASE.
- rst asserted in the STROBE cycle -> next cycle load=0, state IDLE, no ack. Re-request then completes normally with requester 0 as highest priority.
- With REGBANK_WB_STATS_EN, 65536 back-to-back writes to addr=3 -> wr_count wraps to 0.

Source files
------------

// File: rtl/regbank_wb_arbiter.sv
// Round-robin write-back arbiter and load-strobe sequencer for the register bank write port.
// Optional counters wr_count/drop_count are enabled with `define REGBANK_WB_STATS_EN.
module regbank_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 load,
    output logic [AW-1:0]        des1,
    output logic [DW-1:0]        w1,
    output logic                 busy,
    output logic [2:0]           grant_id
`ifdef REGBANK_WB_STATS_EN
    ,
    output logic [15:0]          wr_count,
    output logic [15:0]          drop_count
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

    state_t          state, nxt_state;
    logic [2:0]      ptr;
    logic [2:0]      gid_inc;
    logic [2:0]      start;
    logic [7:0]      mreq;
    logic [2:0]      idx;
    logic [2:0]      win;
    logic            found;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic [AW-1:0]   nxt_des1;
    logic [DW-1:0]   nxt_w1;
    logic [2:0]      nxt_gid;

    assign gid_inc = (grant_id == 3'(NREQ-1)) ? 3'd0 : grant_id + 3'd1;

    // In RELEASE the just-acked requester is masked and search starts after it.
    always_comb begin
        start = (state == RELEASE) ? gid_inc : ptr;
        mreq  = 8'(req);
        if (state == RELEASE)
            mreq[grant_id] = 1'b0;
        found = 1'b0;
        win   = 3'd0;
        idx   = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = 3'((int'(start) + k) % NREQ);
            if (!found && mreq[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == win) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_des1  = des1;
        nxt_w1    = w1;
        nxt_gid   = grant_id;
        case (state)
            IDLE: begin
                if (found) begin
                    nxt_state = SETUP;
                    nxt_des1  = win_addr;
                    nxt_w1    = win_data;
                    nxt_gid   = win;
                end
            end
            SETUP:   nxt_state = (des1 == '0) ? RELEASE : STROBE;
            STROBE:  nxt_state = RELEASE;
            RELEASE: begin
                if (found) begin
                    nxt_state = SETUP;
                    nxt_des1  = win_addr;
                    nxt_w1    = win_data;
                    nxt_gid   = win;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            des1     <= '0;
            w1       <= '0;
            grant_id <= 3'd0;
            load     <= 1'b0;
            busy     <= 1'b0;
            ack      <= '0;
        end else begin
            state    <= nxt_state;
            des1     <= nxt_des1;
            w1       <= nxt_w1;
            grant_id <= nxt_gid;
            load     <= (nxt_state == STROBE);
            busy     <= (nxt_state != IDLE);
            ack      <= (nxt_state == RELEASE) ? (NREQ'(1) << grant_id) : '0;
            if (state == RELEASE)
                ptr <= gid_inc;
        end
    end

`ifdef REGBANK_WB_STATS_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_count   <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            if (state == STROBE)
                wr_count <= wr_count + 16'd1;
            if (state == RELEASE && des1 == '0)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: latency, round-robin order, r0 drop, capture and reset.
module tb_regbank_wb_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 4;

    logic                clock = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     ack;
    logic                load;
    logic [AW-1:0]       des1;
    logic [DW-1:0]       w1;
    logic                busy;
    logic [2:0]          grant_id;
`ifdef REGBANK_WB_STATS_EN
    logic [15:0]         wr_count;
    logic [15:0]         drop_count;
`endif

    int tests  = 0;
    int failed = 0;

    regbank_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clock(clock), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .load(load), .des1(des1), .w1(w1), .busy(busy), .grant_id(grant_id)
`ifdef REGBANK_WB_STATS_EN
        , .wr_count(wr_count), .drop_count(drop_count)
`endif
    );

    always #5 clock = ~clock;

    // Advance one rising edge; sample/drive on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_addr = '0; req_data = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (load !== 1'b0 || busy !== 1'b0 || ack !== 3'b000 || des1 !== 4'd0 || w1 !== 32'd0 || grant_id !== 3'd0) begin
            failed++;
            $display("FAIL reset: load=%b busy=%b ack=%b des1=%0d w1=%h gid=%0d, want all zero",
                     load, busy, ack, des1, w1, grant_id);
        end
    endtask

    task automatic test_single();
        req = 3'b001; req_addr[0 +: AW] = 4'd5; req_data[0 +: DW] = 32'hDEADBEEF;
        tick();  // SETUP
        tests++;
        if (des1 !== 4'd5 || w1 !== 32'hDEADBEEF || load !== 1'b0 || busy !== 1'b1 || ack !== 3'b000) begin
            failed++;
            $display("FAIL single_setup: des1=%0d w1=%h load=%b busy=%b ack=%b, want 5 deadbeef 0 1 000",
                     des1, w1, load, busy, ack);
        end
        tick();  // STROBE
        tests++;
        if (load !== 1'b1 || ack !== 3'b000) begin
            failed++;
            $display("FAIL single_strobe: load=%b ack=%b, want 1 000", load, ack);
        end
        tick();  // RELEASE
        tests++;
        if (load !== 1'b0 || ack !== 3'b001 || des1 !== 4'd5) begin
            failed++;
            $display("FAIL single_release: load=%b ack=%b des1=%0d, want 0 001 5", load, ack, des1);
        end
        req = 3'b000;
        tick();
        tests++;
        if (busy !== 1'b0 || ack !== 3'b000 || load !== 1'b0 || des1 !== 4'd5) begin
            failed++;
            $display("FAIL single_idle: busy=%b ack=%b load=%b des1=%0d, want 0 000 0 5", busy, ack, load, des1);
        end
    endtask

    // After the single write the pointer sits at 1, so 0 and 2 both pending -> 2 wins.
    task automatic test_rr_pointer();
        req = 3'b101;
        req_addr = {4'd9, 4'd0, 4'd8};
        req_data = {32'h0000_0222, 32'h0, 32'h0000_0111};
        tick();
        tests++;
        if (grant_id !== 3'd2 || des1 !== 4'd9 || w1 !== 32'h222) begin
            failed++;
            $display("FAIL rr_pointer: gid=%0d des1=%0d w1=%h, want 2 9 222", grant_id, des1, w1);
        end
        tick(); tick();
        req = 3'b001;
        tick();
        tests++;
        if (grant_id !== 3'd0 || des1 !== 4'd8 || busy !== 1'b1) begin
            failed++;
            $display("FAIL rr_next: gid=%0d des1=%0d busy=%b, want 0 8 1", grant_id, des1, busy);
        end
        tick(); tick();
        req = 3'b000;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 3'b111;
        req_addr = {4'd3, 4'd2, 4'd1};
        req_data = {32'hC3, 32'hB2, 32'hA1};
        tick();
        for (int g = 0; g < 3; g++) begin
            logic [31:0] dexp;
            dexp = (g == 0) ? 32'hA1 : (g == 1) ? 32'hB2 : 32'hC3;
            tests++;
            if (grant_id !== 3'(g) || des1 !== 4'(g + 1) || w1 !== dexp || load !== 1'b0) begin
                failed++;
                $display("FAIL b2b_setup%0d: gid=%0d des1=%0d w1=%h load=%b, want %0d %0d %h 0",
                         g, grant_id, des1, w1, load, g, g + 1, dexp);
            end
            tick();
            tests++;
            if (load !== 1'b1) begin
                failed++;
                $display("FAIL b2b_strobe%0d: load=%b, want 1", g, load);
            end
            tick();
            tests++;
            if (ack !== 3'(1 << g) || load !== 1'b0) begin
                failed++;
                $display("FAIL b2b_ack%0d: ack=%b load=%b, want %b 0", g, ack, load, 3'(1 << g));
            end
            req[g] = 1'b0;
            tick();
        end
        tests++;
        if (busy !== 1'b0 || ack !== 3'b000) begin
            failed++;
            $display("FAIL b2b_idle: busy=%b ack=%b, want 0 000", busy, ack);
        end
    endtask

    task automatic test_r0_drop();
        do_reset();
        req = 3'b010; req_addr = {4'd0, 4'd0, 4'd0}; req_data = {32'h0, 32'h5555, 32'h0};
        tick();
        tests++;
        if (grant_id !== 3'd1 || load !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL r0_setup: gid=%0d load=%b busy=%b, want 1 0 1", grant_id, load, busy);
        end
        tick();
        tests++;
        if (ack !== 3'b010 || load !== 1'b0) begin
            failed++;
            $display("FAIL r0_ack: ack=%b load=%b, want 010 0", ack, load);
        end
        req = 3'b000;
        tick();
        tests++;
        if (busy !== 1'b0 || load !== 1'b0 || ack !== 3'b000) begin
            failed++;
            $display("FAIL r0_idle: busy=%b load=%b ack=%b, want 0 0 000", busy, load, ack);
        end
`ifdef REGBANK_WB_STATS_EN
        tests++;
        if (drop_count !== 16'd1 || wr_count !== 16'd0) begin
            failed++;
            $display("FAIL r0_stats: drop=%0d wr=%0d, want 1 0", drop_count, wr_count);
        end
`endif
    endtask

    task automatic test_capture();
        do_reset();
        req = 3'b100; req_addr = {4'd7, 4'd0, 4'd0}; req_data = {32'h11, 32'h0, 32'h0};
        tick();  // SETUP
        req_data[2*DW +: DW] = 32'h22;
        req_addr[2*AW +: AW] = 4'd12;
        tick();  // STROBE
        tests++;
        if (w1 !== 32'h11 || des1 !== 4'd7 || load !== 1'b1) begin
            failed++;
            $display("FAIL capture_strobe: w1=%h des1=%0d load=%b, want 11 7 1", w1, des1, load);
        end
        tick();  // RELEASE
        tests++;
        if (w1 !== 32'h11 || des1 !== 4'd7 || ack !== 3'b100) begin
            failed++;
            $display("FAIL capture_release: w1=%h des1=%0d ack=%b, want 11 7 100", w1, des1, ack);
        end
        req = 3'b000;
        tick();
`ifdef REGBANK_WB_STATS_EN
        tests++;
        if (wr_count !== 16'd1 || drop_count !== 16'd0) begin
            failed++;
            $display("FAIL capture_stats: wr=%0d drop=%0d, want 1 0", wr_count, drop_count);
        end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        // Move the pointer off 0 first so the post-reset priority is meaningful.
        req = 3'b001; req_addr = {4'd6, 4'd0, 4'd4}; req_data = {32'h66, 32'h0, 32'h44};
        tick(); tick(); tick();
        req = 3'b000;
        tick();
        req = 3'b010; req_addr[1*AW +: AW] = 4'd2;
        tick(); tick();  // STROBE of requester 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (load !== 1'b0 || busy !== 1'b0 || ack !== 3'b000) begin
            failed++;
            $display("FAIL midrst: load=%b busy=%b ack=%b, want 0 0 000", load, busy, ack);
        end
        req = 3'b111;
        tick();
        tests++;
        if (grant_id !== 3'd0 || des1 !== 4'd4) begin
            failed++;
            $display("FAIL midrst_prio: gid=%0d des1=%0d, want 0 4", grant_id, des1);
        end
        tick(); tick();
        tests++;
        if (ack !== 3'b001) begin
            failed++;
            $display("FAIL midrst_ack: ack=%b, want 001", ack);
        end
        req = 3'b110;
        tick();
        tests++;
        if (grant_id !== 3'd1 || des1 !== 4'd2) begin
            failed++;
            $display("FAIL midrst_next: gid=%0d des1=%0d, want 1 2", grant_id, des1);
        end
        tick(); tick();
        req = 3'b100;
        tick(); tick(); tick();
        req = 3'b000;
        tick();
    endtask

    // Watchdog: load must never stay high two cycles running.
    logic load_q = 1'b0;
    always @(negedge clock) begin
        if (load && load_q) begin
            tests++;
            failed++;
            $display("FAIL load_width: load=%b prev=%b, want not both 1", load, load_q);
        end
        load_q <= load;
    end

    initial begin
        test_reset();
        test_single();
        test_rr_pointer();
        test_back_to_back();
        test_r0_drop();
        test_capture();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded, want completion");
        $fatal(1);
    end
endmodule
